spi_xfer_arbiter: RTL and testbench
===================================

Name: spi_xfer_arbiter

Overview:
Shares one SPI master byte engine between NREQ requesters and sequences multi-byte transactions through it. Round-robin arbitration grants one requester per transaction. The block holds the master's active-low ENABLE asserted for exactly REQ_LEN bytes, feeds MOSI_data, and returns MISO_data bytes. Byte completion is detected from changes of the master's stash_ptr; a watchdog aborts stalled transfers.

Parameters:
NREQ, 2, number of requesters (2..8)
LEN_W, 8, width of per-requester byte count
MIN_GAP, 4, CTRL_CLK cycles CS must stay high between transactions
TIMEOUT, 4096, CTRL_CLK cycles allowed per byte before abort

Ports:
CTRL_CLK  in  1  single clock
NRST  in  1  reset, asynchronous, active-low
REQ  in  NREQ  level request per requester
REQ_LEN  in  NREQ*LEN_W  bytes requested; slice i belongs to requester i
TX_DATA  in  NREQ*8  next byte to send, per requester
GNT  out  NREQ  one-hot grant, high for the whole transaction
TX_POP  out  NREQ  1-cycle pulse: granted requester's TX_DATA consumed; present the next byte
RX_DATA  out  8  received byte
RX_VALID  out  NREQ  1-cycle pulse to the granted requester; RX_DATA valid
DONE  out  NREQ  1-cycle pulse: transaction complete
ERR  out  NREQ  1-cycle pulse: transaction aborted by watchdog
SPI_EN_N  out  1  to master ENABLE; 0 = run transfers
MOSI_data  out  8  to master byte input
MISO_data  in  8  from master received byte
stash_ptr  in  8  from master; increments once per completed byte
CS_IN  in  1  master CS, 1 = idle

Behaviour:
- Reset (async, NRST=0): GNT=0, TX_POP=0, RX_VALID=0, DONE=0, ERR=0, RX_DATA=0, MOSI_data=0, SPI_EN_N=1, FSM=IDLE, rr_last=NREQ-1 (requester 0 wins first). Reset mid-transaction takes effect immediately, with no DONE or ERR.
- FSM states: IDLE, XFER, GAP.
- IDLE: the candidate set is REQ[i] with REQ_LEN[i]!=0. A requester with zero length is never granted. The winner is the first candidate searching upward from rr_last+1, with wrap.
  - On a win, next cycle: GNT[w]=1, rr_last=w, remaining=REQ_LEN[w], ptr_q=stash_ptr, MOSI_data=TX_DATA[w], SPI_EN_N=0, FSM=XFER.
- XFER:
  - MOSI_data is registered from TX_DATA[w] every cycle.
  - byte_done = (stash_ptr != ptr_q). Comparison is by inequality, so a 255->0 wrap counts as a completion.
  - On byte_done, in the same cycle:
    - ptr_q=stash_ptr, RX_DATA=MISO_data, RX_VALID[w]=1, TX_POP[w]=1, remaining-=1, watchdog cleared.
    - If remaining was 1: SPI_EN_N=1, DONE[w]=1, GNT cleared, FSM=GAP.
  - The requester must update TX_DATA within 1 cycle after TX_POP.
  - Watchdog counts cycles in XFER without byte_done. On reaching TIMEOUT: SPI_EN_N=1, ERR[w]=1, GNT cleared, FSM=GAP, no DONE.
- GAP: counts consecutive cycles with CS_IN=1. After MIN_GAP such cycles, FSM=IDLE. CS_IN=0 restarts the count.
- REQ, REQ_LEN and the other requesters are ignored outside IDLE. Dropping REQ mid-transaction does not shorten it.
- At most one bit of GNT, TX_POP, RX_VALID, DONE and ERR is set in any cycle.
- DONE and ERR never pulse in the same cycle.
- Simultaneous byte_done and watchdog expiry: byte_done wins.
- Width rules: remaining is LEN_W bits. The watchdog counter is clog2(TIMEOUT+1) bits and saturates.

Decomposition:
- Shared package spi_pkg: FSM state encoding (IDLE/XFER/GAP) and SPI byte width (8).
- One sub-module, spi_rr_arbiter: combinational round-robin pick from (candidates, rr_last) to a one-hot winner plus a valid flag, parameterised by NREQ.

Test Plan:
- Single 3-byte transfer: REQ[0]=1, REQ_LEN[0]=3, TX_DATA 0xA5/0x3C/0xFF; master model echoes bytes -> SPI_EN_N low for 3 byte_done events, 3 RX_VALID[0] with 0xA5/0x3C/0xFF, 3 TX_POP[0], DONE[0] once, then SPI_EN_N=1.
- Contention: REQ=2'b11, each length 1, held -> grants alternate 0,1,0,1; no two GNT bits set together; MIN_GAP CS-high cycles between grants.
- Zero length: REQ[1]=1, REQ_LEN[1]=0 -> GNT[1] never asserted; SPI_EN_N stays 1.
- stash_ptr wrap: start at 0xFE, 3-byte transfer -> pointer goes 0xFF, 0x00, 0x01; 3 RX_VALID; DONE.
- Stall: master never increments stash_ptr, TIMEOUT=16 -> ERR[w] on cycle 16 of XFER, SPI_EN_N=1, no DONE, next request is served after the gap.
- Async reset mid-transfer after byte 1 of 4 -> all outputs immediately at reset values, no DONE/ERR; next grant goes to requester 0.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared constants and FSM state encoding for the SPI
//                transaction arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Width of one SPI data byte
    localparam int c_BYTE_W = 8;

    // Transaction sequencer states
    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_XFER = 2'd1;
    localparam state_t c_ST_GAP  = 2'd2;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : spi_rr_arbiter
//  Description : Combinational round-robin pick. Searches upward from
//                i_last+1 (with wrap) for the first candidate and returns it
//                as a one-hot grant, an index and a valid flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  i_cand,
    input  logic [IDX_W-1:0] i_last,
    output logic [NREQ-1:0]  o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    // First candidate after the previous winner wins; the previous winner
    // itself is looked at last so it cannot starve the others.
    always_comb begin
        logic [IDX_W-1:0] v_sel;
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        v_sel   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            v_sel = IDX_W'((int'(i_last) + k) % NREQ);
            if (!o_valid && i_cand[v_sel]) begin
                o_valid      = 1'b1;
                o_idx        = v_sel;
                o_gnt[v_sel] = 1'b1;
            end
        end
    end

endmodule : spi_rr_arbiter
`default_nettype wire

// File: rtl/spi_xfer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : spi_xfer_arbiter
//  Description : Shares one SPI master byte engine among NREQ requesters.
//                Grants one requester per multi-byte transaction (round
//                robin), holds ENABLE low for exactly REQ_LEN bytes, detects
//                byte completion from stash_ptr changes and aborts stalled
//                transfers with a watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_xfer_arbiter
    import spi_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int LEN_W   = 8,
    parameter int MIN_GAP = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                     CTRL_CLK,
    input  logic                     NRST,
    input  logic [NREQ-1:0]          REQ,
    input  logic [NREQ*LEN_W-1:0]    REQ_LEN,
    input  logic [NREQ*c_BYTE_W-1:0] TX_DATA,
    output logic [NREQ-1:0]          GNT,
    output logic [NREQ-1:0]          TX_POP,
    output logic [c_BYTE_W-1:0]      RX_DATA,
    output logic [NREQ-1:0]          RX_VALID,
    output logic [NREQ-1:0]          DONE,
    output logic [NREQ-1:0]          ERR,
    output logic                     SPI_EN_N,
    output logic [c_BYTE_W-1:0]      MOSI_data,
    input  logic [c_BYTE_W-1:0]      MISO_data,
    input  logic [c_BYTE_W-1:0]      stash_ptr,
    input  logic                     CS_IN
);

    localparam int c_IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_WD_W  = $clog2(TIMEOUT + 1);
    localparam int c_GAP_W = $clog2(MIN_GAP + 1);

    localparam logic [c_WD_W-1:0]  c_WD_LIMIT = c_WD_W'(TIMEOUT - 1);
    localparam logic [c_WD_W-1:0]  c_WD_SAT   = c_WD_W'(TIMEOUT);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(MIN_GAP - 1);
    localparam logic [c_IDX_W-1:0] c_RR_INIT  = c_IDX_W'(NREQ - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t               r_state;
    logic [NREQ-1:0]      r_gnt;
    logic [NREQ-1:0]      r_tx_pop;
    logic [NREQ-1:0]      r_rx_valid;
    logic [NREQ-1:0]      r_done;
    logic [NREQ-1:0]      r_err;
    logic [c_BYTE_W-1:0]  r_rx_data;
    logic [c_BYTE_W-1:0]  r_mosi;
    logic                 r_spi_en_n;
    logic [LEN_W-1:0]     r_remaining;
    logic [c_BYTE_W-1:0]  r_ptr_q;
    logic [c_WD_W-1:0]    r_wdog;
    logic [c_GAP_W-1:0]   r_gap_cnt;
    logic [c_IDX_W-1:0]   r_rr_last;

    // ------------------------------------------------------------------
    // Combinational next values
    // ------------------------------------------------------------------
    state_t               w_state_nxt;
    logic [NREQ-1:0]      w_gnt_nxt;
    logic [NREQ-1:0]      w_tx_pop_nxt;
    logic [NREQ-1:0]      w_rx_valid_nxt;
    logic [NREQ-1:0]      w_done_nxt;
    logic [NREQ-1:0]      w_err_nxt;
    logic [c_BYTE_W-1:0]  w_rx_data_nxt;
    logic [c_BYTE_W-1:0]  w_mosi_nxt;
    logic                 w_spi_en_n_nxt;
    logic [LEN_W-1:0]     w_remaining_nxt;
    logic [c_BYTE_W-1:0]  w_ptr_q_nxt;
    logic [c_WD_W-1:0]    w_wdog_nxt;
    logic [c_GAP_W-1:0]   w_gap_cnt_nxt;
    logic [c_IDX_W-1:0]   w_rr_last_nxt;

    logic [NREQ-1:0]      w_cand;
    logic [NREQ-1:0]      w_pick_gnt;
    logic [c_IDX_W-1:0]   w_pick_idx;
    logic                 w_pick_valid;
    logic [LEN_W-1:0]     w_len_arr [NREQ];
    logic [c_BYTE_W-1:0]  w_tx_arr  [NREQ];
    logic                 w_byte_done;
    logic                 w_last_byte;
    logic                 w_wdog_expire;
    logic                 w_gap_done;

    // Unpack the flat per-requester buses; zero-length requests never compete
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_len_arr[gi] = REQ_LEN[gi*LEN_W +: LEN_W];
        assign w_tx_arr[gi]  = TX_DATA[gi*c_BYTE_W +: c_BYTE_W];
        assign w_cand[gi]    = REQ[gi] && (w_len_arr[gi] != '0);
    end

    spi_rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (c_IDX_W)
    ) u_rr_arbiter (
        .i_cand  (w_cand),
        .i_last  (r_rr_last),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    // Inequality (not increment) detection so a 255->0 pointer wrap counts
    assign w_byte_done   = (r_state == c_ST_XFER) && (stash_ptr != r_ptr_q);
    assign w_last_byte   = (r_remaining == LEN_W'(1));
    assign w_wdog_expire = (r_wdog >= c_WD_LIMIT);
    assign w_gap_done    = CS_IN && (r_gap_cnt >= c_GAP_LAST);

    // FSM state register
    always_ff @(posedge CTRL_CLK or negedge NRST) begin
        if (!NRST) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; a completed byte takes priority over the watchdog
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = c_ST_XFER;
                end
            end
            c_ST_XFER: begin
                if (w_byte_done) begin
                    if (w_last_byte) begin
                        w_state_nxt = c_ST_GAP;
                    end
                end else if (w_wdog_expire) begin
                    w_state_nxt = c_ST_GAP;
                end
            end
            c_ST_GAP: begin
                if (w_gap_done) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // FSM output logic: next values of all registered outputs and counters
    always_comb begin
        w_gnt_nxt       = r_gnt;
        w_tx_pop_nxt    = '0;
        w_rx_valid_nxt  = '0;
        w_done_nxt      = '0;
        w_err_nxt       = '0;
        w_rx_data_nxt   = r_rx_data;
        w_mosi_nxt      = r_mosi;
        w_spi_en_n_nxt  = r_spi_en_n;
        w_remaining_nxt = r_remaining;
        w_ptr_q_nxt     = r_ptr_q;
        w_wdog_nxt      = r_wdog;
        w_gap_cnt_nxt   = r_gap_cnt;
        w_rr_last_nxt   = r_rr_last;
        case (r_state)
            c_ST_IDLE: begin
                if (w_pick_valid) begin
                    w_gnt_nxt       = w_pick_gnt;
                    w_rr_last_nxt   = w_pick_idx;
                    w_remaining_nxt = w_len_arr[w_pick_idx];
                    w_ptr_q_nxt     = stash_ptr;
                    w_mosi_nxt      = w_tx_arr[w_pick_idx];
                    w_spi_en_n_nxt  = 1'b0;
                    w_wdog_nxt      = '0;
                end
            end
            c_ST_XFER: begin
                // The granted requester refreshes TX_DATA after each pop,
                // so MOSI simply follows it every cycle.
                w_mosi_nxt = w_tx_arr[r_rr_last];
                if (w_byte_done) begin
                    w_ptr_q_nxt     = stash_ptr;
                    w_rx_data_nxt   = MISO_data;
                    w_rx_valid_nxt  = r_gnt;
                    w_tx_pop_nxt    = r_gnt;
                    w_remaining_nxt = r_remaining - LEN_W'(1);
                    w_wdog_nxt      = '0;
                    if (w_last_byte) begin
                        w_spi_en_n_nxt = 1'b1;
                        w_done_nxt     = r_gnt;
                        w_gnt_nxt      = '0;
                        w_gap_cnt_nxt  = '0;
                    end
                end else if (w_wdog_expire) begin
                    w_spi_en_n_nxt = 1'b1;
                    w_err_nxt      = r_gnt;
                    w_gnt_nxt      = '0;
                    w_gap_cnt_nxt  = '0;
                end else if (r_wdog != c_WD_SAT) begin
                    w_wdog_nxt = r_wdog + c_WD_W'(1);
                end
            end
            c_ST_GAP: begin
                // Only consecutive CS-high cycles count toward the gap
                if (!CS_IN) begin
                    w_gap_cnt_nxt = '0;
                end else if (!w_gap_done) begin
                    w_gap_cnt_nxt = r_gap_cnt + c_GAP_W'(1);
                end
            end
            default: begin
                w_gnt_nxt      = '0;
                w_spi_en_n_nxt = 1'b1;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge CTRL_CLK or negedge NRST) begin
        if (!NRST) begin
            r_gnt       <= '0;
            r_tx_pop    <= '0;
            r_rx_valid  <= '0;
            r_done      <= '0;
            r_err       <= '0;
            r_rx_data   <= '0;
            r_mosi      <= '0;
            r_spi_en_n  <= 1'b1;
            r_remaining <= '0;
            r_ptr_q     <= '0;
            r_wdog      <= '0;
            r_gap_cnt   <= '0;
            r_rr_last   <= c_RR_INIT;
        end else begin
            r_gnt       <= w_gnt_nxt;
            r_tx_pop    <= w_tx_pop_nxt;
            r_rx_valid  <= w_rx_valid_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_rx_data   <= w_rx_data_nxt;
            r_mosi      <= w_mosi_nxt;
            r_spi_en_n  <= w_spi_en_n_nxt;
            r_remaining <= w_remaining_nxt;
            r_ptr_q     <= w_ptr_q_nxt;
            r_wdog      <= w_wdog_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
            r_rr_last   <= w_rr_last_nxt;
        end
    end

    assign GNT       = r_gnt;
    assign TX_POP    = r_tx_pop;
    assign RX_VALID  = r_rx_valid;
    assign DONE      = r_done;
    assign ERR       = r_err;
    assign RX_DATA   = r_rx_data;
    assign MOSI_data = r_mosi;
    assign SPI_EN_N  = r_spi_en_n;

endmodule : spi_xfer_arbiter
`default_nettype wire

// File: tb/tb_spi_xfer_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_spi_xfer_arbiter
//  Description : Self-checking bench for spi_xfer_arbiter. A transaction-level
//                model predicts grants, echoed bytes, completion and aborts;
//                a simple SPI master model echoes MOSI back on MISO.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_xfer_arbiter;

    localparam int NREQ    = 2;
    localparam int LEN_W   = 8;
    localparam int MIN_GAP = 4;
    localparam int TIMEOUT = 16;

    logic                   CTRL_CLK  = 1'b0;
    logic                   NRST      = 1'b1;
    logic [NREQ-1:0]        REQ       = '0;
    logic [NREQ*LEN_W-1:0]  REQ_LEN   = '0;
    logic [NREQ*8-1:0]      TX_DATA   = '0;
    logic [NREQ-1:0]        GNT, TX_POP, RX_VALID, DONE, ERR;
    logic [7:0]             RX_DATA, MOSI_data;
    logic                   SPI_EN_N;
    logic [7:0]             MISO_data = 8'h00;
    logic [7:0]             stash_ptr = 8'h00;
    logic                   CS_IN     = 1'b1;

    spi_xfer_arbiter #(
        .NREQ    (NREQ),
        .LEN_W   (LEN_W),
        .MIN_GAP (MIN_GAP),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CTRL_CLK  (CTRL_CLK),
        .NRST      (NRST),
        .REQ       (REQ),
        .REQ_LEN   (REQ_LEN),
        .TX_DATA   (TX_DATA),
        .GNT       (GNT),
        .TX_POP    (TX_POP),
        .RX_DATA   (RX_DATA),
        .RX_VALID  (RX_VALID),
        .DONE      (DONE),
        .ERR       (ERR),
        .SPI_EN_N  (SPI_EN_N),
        .MOSI_data (MOSI_data),
        .MISO_data (MISO_data),
        .stash_ptr (stash_ptr),
        .CS_IN     (CS_IN)
    );

    always #5 CTRL_CLK = ~CTRL_CLK;

    // Requester byte streams
    logic [7:0] data [NREQ][256];
    int         pos  [NREQ];

    // Transaction model
    int  n_checks = 0;
    int  n_fail   = 0;
    bit  m_busy   = 1'b0;
    bit  m_stall  = 1'b0;
    int  m_w, m_len, m_bytes, m_start, m_xcyc;
    int  m_last   = NREQ - 1;
    int  m_gap    = MIN_GAP;
    int  n_done   = 0;
    int  n_err    = 0;
    logic [7:0] rx_log [$];

    // Master model
    int         mcnt    = 0;
    int         mblen   = 3;
    int         cs_tail = 0;
    logic [7:0] mlat    = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Round-robin choice straight from the arbitration rule
    function automatic int rr_pick(input logic [NREQ-1:0] req,
                                   input logic [NREQ*LEN_W-1:0] len, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (last + k) % NREQ;
            if (req[idx] && (len[idx*LEN_W +: LEN_W] != '0)) return idx;
        end
        return -1;
    endfunction

    task automatic drive_tx();
        for (int i = 0; i < NREQ; i++) TX_DATA[i*8 +: 8] = data[i][pos[i]];
    endtask

    task automatic set_len(input int i, input int v);
        REQ_LEN[i*LEN_W +: LEN_W] = LEN_W'(v);
    endtask

    task automatic check_reset(input string tag);
        logic [31:0] v;
        v = {6'd0, GNT, TX_POP, RX_VALID, DONE, ERR, RX_DATA, MOSI_data};
        chk({tag, "_out"}, v, 32'd0);
        chk({tag, "_en"}, {31'd0, SPI_EN_N}, 32'd1);
    endtask

    // One clock: check outputs at the negedge, then advance requester/master models
    task automatic step();
        logic [NREQ-1:0]       s_req;
        logic [NREQ*LEN_W-1:0] s_len;
        logic                  s_cs;
        logic [NREQ-1:0]       exp_g;
        int                    pick;
        @(negedge CTRL_CLK);
        s_req = REQ;
        s_len = REQ_LEN;
        s_cs  = CS_IN;
        chk("excl", {$onehot0(GNT), $onehot0(TX_POP), $onehot0(RX_VALID),
                     $onehot0(DONE), $onehot0(ERR), !((|DONE) && (|ERR))}, 32'h3f);
        chk("en_vs_gnt", {31'd0, SPI_EN_N}, {31'd0, (GNT == '0)});
        if (!m_busy) begin
            pick  = rr_pick(s_req, s_len, m_last);
            exp_g = (m_gap >= MIN_GAP && pick >= 0) ? (NREQ'(1) << pick) : '0;
            chk("grant", GNT, exp_g);
            chk("idle_pulse", {TX_POP, RX_VALID, DONE, ERR}, 0);
            if (GNT != '0) begin
                m_busy  = 1'b1;
                m_w     = (pick >= 0) ? pick : 0;
                m_last  = m_w;
                m_len   = s_len[m_w*LEN_W +: LEN_W];
                m_bytes = 0;
                m_xcyc  = 0;
                m_start = pos[m_w];
            end else begin
                m_gap = s_cs ? m_gap + 1 : 0;
            end
        end else begin
            m_xcyc++;
            if (RX_VALID != '0) begin
                chk("rx_valid", RX_VALID, NREQ'(1) << m_w);
                chk("tx_pop", TX_POP, RX_VALID);
                chk("rx_count", m_bytes < m_len, 1);
                chk("rx_data", RX_DATA, data[m_w][(m_start + m_bytes) % 256]);
                rx_log.push_back(RX_DATA);
                m_bytes++;
            end else begin
                chk("tx_pop_quiet", TX_POP, 0);
            end
            if (DONE != '0) begin
                chk("done", DONE, NREQ'(1) << m_w);
                chk("done_len", m_bytes, m_len);
                chk("done_stall", m_stall, 0);
                m_busy = 1'b0;
                m_gap  = 0;
                n_done++;
            end else if (ERR != '0) begin
                chk("err", ERR, NREQ'(1) << m_w);
                chk("err_cycle", m_xcyc, TIMEOUT);
                chk("err_stall", m_stall, 1);
                m_busy = 1'b0;
                m_gap  = 0;
                n_err++;
            end else begin
                chk("gnt_hold", GNT, NREQ'(1) << m_w);
            end
        end
        for (int i = 0; i < NREQ; i++) if (TX_POP[i]) pos[i] = (pos[i] + 1) % 256;
        drive_tx();
        if (!SPI_EN_N) begin
            CS_IN   = 1'b0;
            cs_tail = $urandom_range(0, 2);
            if (!m_stall) begin
                mcnt++;
                if (mcnt == 2) mlat = MOSI_data;
                if (mcnt >= mblen) begin
                    MISO_data = mlat;
                    stash_ptr = stash_ptr + 8'd1;
                    mcnt      = 0;
                    mblen     = $urandom_range(3, 6);
                end
            end
        end else begin
            mcnt = 0;
            if (cs_tail > 0) begin
                cs_tail--;
                CS_IN = 1'b0;
            end else begin
                CS_IN = 1'b1;
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic run_until_busy(input int lim);
        int k = 0;
        while (!m_busy && k < lim) begin step(); k++; end
        chk("wait_busy", m_busy, 1);
    endtask

    task automatic run_until_idle(input int lim);
        int k = 0;
        while (m_busy && k < lim) begin step(); k++; end
        chk("wait_idle", m_busy, 0);
    endtask

    initial begin
        int d0;
        int k;
        for (int i = 0; i < NREQ; i++) begin
            pos[i] = 0;
            for (int j = 0; j < 256; j++) data[i][j] = 8'($urandom);
        end
        drive_tx();
        stash_ptr = 8'($urandom);
        #1 NRST = 1'b0;
        repeat (3) @(negedge CTRL_CLK);
        check_reset("rst");
        NRST = 1'b1;

        // Single 3-byte transfer with known data
        data[0][pos[0]]           = 8'hA5;
        data[0][(pos[0] + 1)%256] = 8'h3C;
        data[0][(pos[0] + 2)%256] = 8'hFF;
        drive_tx();
        rx_log.delete();
        set_len(0, 3);
        REQ = 2'b01;
        run_until_busy(20);
        REQ = 2'b00;
        run_until_idle(100);
        chk("t1_done", n_done, 1);
        chk("t1_nrx", rx_log.size(), 3);
        if (rx_log.size() == 3) begin
            chk("t1_rx0", rx_log[0], 8'hA5);
            chk("t1_rx1", rx_log[1], 8'h3C);
            chk("t1_rx2", rx_log[2], 8'hFF);
        end

        // Contention: both requesters, length 1, held
        set_len(0, 1);
        set_len(1, 1);
        REQ = 2'b11;
        d0  = n_done;
        run(80);
        REQ = 2'b00;
        run_until_idle(50);
        chk("t2_count", (n_done - d0) >= 4, 1);

        // Zero length is never granted
        d0 = n_done;
        set_len(1, 0);
        set_len(0, 5);
        REQ = 2'b10;
        run(40);
        chk("t3_done", n_done, d0);
        chk("t3_en", SPI_EN_N, 1);
        REQ = 2'b00;

        // stash_ptr wrap through 0xFF -> 0x00
        run(MIN_GAP + 2);
        stash_ptr = 8'hFE;
        d0 = n_done;
        set_len(0, 3);
        REQ = 2'b01;
        run_until_busy(20);
        REQ = 2'b00;
        run_until_idle(100);
        chk("t4_done", n_done - d0, 1);
        chk("t4_ptr", stash_ptr, 8'h01);

        // Stalled master triggers the watchdog, then service resumes
        m_stall = 1'b1;
        set_len(1, 2);
        REQ = 2'b10;
        run_until_busy(20);
        REQ = 2'b00;
        run_until_idle(TIMEOUT + 20);
        chk("t5_err", n_err, 1);
        m_stall = 1'b0;
        d0 = n_done;
        set_len(0, 1);
        REQ = 2'b01;
        run_until_busy(20);
        REQ = 2'b00;
        run_until_idle(50);
        chk("t5_after", n_done - d0, 1);

        // Asynchronous reset after byte 1 of 4
        set_len(0, 4);
        REQ = 2'b01;
        run_until_busy(20);
        REQ = 2'b00;
        k = 0;
        while (m_bytes < 1 && k < 50) begin step(); k++; end
        chk("t6_byte1", m_bytes, 1);
        #2 NRST = 1'b0;
        #1 check_reset("t6_rst");
        m_busy  = 1'b0;
        m_last  = NREQ - 1;
        m_gap   = MIN_GAP;
        mcnt    = 0;
        cs_tail = 0;
        CS_IN   = 1'b1;
        @(negedge CTRL_CLK);
        @(negedge CTRL_CLK);
        chk("t6_quiet", {DONE, ERR}, 0);
        NRST = 1'b1;
        set_len(0, 1);
        set_len(1, 1);
        REQ = 2'b11;
        run_until_busy(20);
        chk("t6_first", m_w, 0);
        REQ = 2'b00;
        run_until_idle(50);

        // Randomised traffic
        for (int e = 0; e < 40; e++) begin
            REQ = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) set_len(i, $urandom_range(0, 4));
            run($urandom_range(1, 25));
        end
        REQ = '0;
        run_until_idle(200);
        run(MIN_GAP + 4);
        chk("err_total", n_err, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_spi_xfer_arbiter
`default_nettype wire
